avalon_pio_bank: RTL

//  Parametrised multi-channel PIO bank on an Avalon-MM slave behind pcie_hard_ip_0 BAR.

---
 rtl/pio_pkg.sv | 21 ++
 rtl/pio_channel.sv | 95 +++++++++
 rtl/avalon_pio_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO bank: register offsets, edge modes, address sizing.
package pio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    function automatic int addr_w(input int n_ch);
        return $clog2(n_ch) + 3;
    endfunction

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: output/direction/mask/capture registers, input synchroniser and edge capture.
module pio_channel
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter edge_mode_e       EDGE_MODE   = EDGE_ANY,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             we_data,
    input  logic             we_dir,
    input  logic             we_mask,
    input  logic             we_w1c,
    input  logic             we_set,
    input  logic             we_clr,
    input  logic [WIDTH-1:0] wd,
    input  logic [2:0]       rd_reg,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic [31:0]      rdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] dly_q, out_q, out_d, oe_q, oe_d, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] in_sync, edge_raw, edge_hit;

    assign in_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = pio_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // Only inputs (oe = 0) capture, and nothing captures until the bank is armed after reset.
    always_comb begin
        edge_raw = in_sync ^ dly_q;
        case (EDGE_MODE)
            EDGE_RISE: edge_raw = in_sync & ~dly_q;
            EDGE_FALL: edge_raw = ~in_sync & dly_q;
            default:   edge_raw = in_sync ^ dly_q;
        endcase
        edge_hit = arm ? (edge_raw & ~oe_q) : '0;
    end

    always_comb begin
        out_d = out_q;
        if (we_data) out_d = wd;
        if (we_set)  out_d = out_q | wd;
        if (we_clr)  out_d = out_q & ~wd;
        oe_d   = we_dir  ? wd : oe_q;
        mask_d = we_mask ? wd : mask_q;
        // A new edge beats a simultaneous write-1-to-clear so no event is lost.
        cap_d  = (cap_q & ~(we_w1c ? wd : '0)) | edge_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            dly_q  <= '0;
            out_q  <= OUT_RESET;
            oe_q   <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= in_sync;
            out_q  <= out_d;
            oe_q   <= oe_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_reg)
            REG_DATA:    rdata = 32'((oe_q & out_q) | (~oe_q & in_sync));
            REG_DIR:     rdata = 32'(oe_q);
            REG_IRQMASK: rdata = 32'(mask_q);
            REG_EDGECAP: rdata = 32'(cap_q);
            default:     rdata = '0;
        endcase
    end

    assign pio_out = out_q;
    assign pio_oe  = oe_q;
    assign irq     = |(cap_q & mask_q);

endmodule

// File: rtl/avalon_pio_bank.sv
// N_CH-channel PIO bank behind an Avalon-MM slave with a single registered level interrupt.
module avalon_pio_bank
    import pio_pkg::*;
#(
    parameter int          N_CH        = 6,
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_MODE   = 2,
    parameter logic [31:0] OUT_RESET   = '0,
    localparam int         ADDR_W      = addr_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic [31:0]            avs_readdata,
    input  logic [N_CH*WIDTH-1:0]  pio_in,
    output logic [N_CH*WIDTH-1:0]  pio_out,
    output logic [N_CH*WIDTH-1:0]  pio_oe,
    output logic                   irq
);

    localparam edge_mode_e EDGE_E = edge_mode_e'(EDGE_MODE[1:0]);

    // Avalon-MM handshake: no waitrequest. A read is accepted on every cycle avs_read is high
    // and its data is on avs_readdata the next cycle; a write commits on the same clock edge.
    // With both strobes high the read returns the value from before the write.
    logic [ADDR_W-1:0] ch_sel;
    logic [2:0]        reg_sel;
    logic [31:0]       ch_rdata [N_CH];
    logic [N_CH-1:0]   ch_irq;
    logic [2:0]        arm_cnt_q, arm_cnt_d;
    logic              arm;
    logic [31:0]       readdata_q, readdata_d, rd_mux;
    logic              irq_q, irq_d;

    assign ch_sel  = avs_address >> 3;
    assign reg_sel = avs_address[2:0];

    // Sync flops come out of reset as zeros; hold off capture until they hold real input.
    assign arm = (arm_cnt_q == 3'(SYNC_STAGES + 1));
    assign arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + 3'd1;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic hit_wr;
        assign hit_wr = avs_write && (ch_sel == ADDR_W'(k));

        pio_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_E),
            .OUT_RESET   (OUT_RESET[WIDTH-1:0])
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .arm     (arm),
            .we_data (hit_wr && reg_sel == REG_DATA),
            .we_dir  (hit_wr && reg_sel == REG_DIR),
            .we_mask (hit_wr && reg_sel == REG_IRQMASK),
            .we_w1c  (hit_wr && reg_sel == REG_EDGECAP),
            .we_set  (hit_wr && reg_sel == REG_OUTSET),
            .we_clr  (hit_wr && reg_sel == REG_OUTCLR),
            .wd      (avs_writedata[WIDTH-1:0]),
            .rd_reg  (reg_sel),
            .pio_in  (pio_in[k*WIDTH +: WIDTH]),
            .pio_out (pio_out[k*WIDTH +: WIDTH]),
            .pio_oe  (pio_oe[k*WIDTH +: WIDTH]),
            .rdata   (ch_rdata[k]),
            .irq     (ch_irq[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel == ADDR_W'(k)) rd_mux = ch_rdata[k];
        end
        readdata_d = avs_read ? rd_mux : '0;
        irq_d      = |ch_irq;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            arm_cnt_q  <= arm_cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule
